// File: rtl/mips_pkg.sv
// Shared constants for the MIPS decode/execute slice.
//   - opcode (inst[31:26]) and R-type funct (inst[5:0]) encodings
//   - alu_op_t: 4-bit ALU operation select carried through ID/EX
//   - ctrl_t: the control half of the ID/EX pipeline register
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Return-address register written by jal.
  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_NOR   = 4'h5,
    ALU_SLT   = 4'h6,
    ALU_SLTU  = 4'h7,
    ALU_SLL   = 4'h8,
    ALU_SRL   = 4'h9,
    ALU_SRA   = 4'hA,
    ALU_LUI   = 4'hB,
    ALU_EQ    = 4'hC,
    ALU_NE    = 4'hD,
    ALU_RSV_E = 4'hE,
    ALU_RSV_F = 4'hF
  } alu_op_t;

  typedef struct packed {
    logic    regdst;
    logic    jump;
    logic    branch;
    logic    jr;
    logic    memread;
    logic    memtoreg;
    logic    memwrite;
    logic    alusrc;
    logic    regwrite;
    logic    savepc;
    alu_op_t alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/mips_alu.sv
// Purely combinational MIPS ALU.
//   operand1 : rs data
//   operand2 : rt data or extended immediate
//   shamt    : shift amount for SLL/SRL/SRA
//   alu_op   : operation select
//   result   : 32-bit result; compare ops return 1/0 (nonzero on a branch = taken)
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [4:0]  shamt,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = operand1 + operand2;
      ALU_SUB:  result = operand1 - operand2;
      ALU_AND:  result = operand1 & operand2;
      ALU_OR:   result = operand1 | operand2;
      ALU_XOR:  result = operand1 ^ operand2;
      ALU_NOR:  result = ~(operand1 | operand2);
      ALU_SLT:  result = {31'b0, $signed(operand1) < $signed(operand2)};
      ALU_SLTU: result = {31'b0, operand1 < operand2};
      // Shifts move the rt operand, matching the MIPS sll/srl/sra form.
      ALU_SLL:  result = operand2 << shamt;
      ALU_SRL:  result = operand2 >> shamt;
      ALU_SRA:  result = $unsigned($signed(operand2) >>> shamt);
      ALU_LUI:  result = {operand2[15:0], 16'h0000};
      ALU_EQ:   result = {31'b0, operand1 == operand2};
      ALU_NE:   result = {31'b0, operand1 != operand2};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_alu_hazard.sv
// Decode, interlock and execute slice of a 5-stage MIPS pipeline (no forwarding).
//   clk, rst                     : clock, synchronous active-high reset
//   id_inst                      : instruction in IF/ID
//   flush                        : squash the ID/EX control entry (branch/jump redirect)
//   ex_mem_wr_reg/_regwrite      : destination of the instruction in EX/MEM
//   mem_wb_wr_reg/_regwrite      : destination of the instruction in MEM/WB
//   ex_operand1/2                : EX operands (operand 2 already muxed outside)
//   stall                        : combinational RAW interlock; hold PC and IF/ID
//   id_ext_imm, id_alusrc        : combinational decode outputs for the operand-B mux
//   ex_*                         : registered ID/EX control, dest, shamt, ALU op
//   ex_alu_result                : combinational ALU result in EX
module mips_ctrl_alu_hazard
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic        flush,
  input  logic [4:0]  ex_mem_wr_reg,
  input  logic        ex_mem_regwrite,
  input  logic [4:0]  mem_wb_wr_reg,
  input  logic        mem_wb_regwrite,
  input  logic [31:0] ex_operand1,
  input  logic [31:0] ex_operand2,
  output logic        stall,
  output logic [31:0] id_ext_imm,
  output logic        id_alusrc,
  output logic        ex_regdst,
  output logic        ex_jump,
  output logic        ex_branch,
  output logic        ex_jr,
  output logic        ex_memread,
  output logic        ex_memtoreg,
  output logic        ex_memwrite,
  output logic        ex_alusrc,
  output logic        ex_regwrite,
  output logic        ex_savepc,
  output logic [4:0]  ex_dest,
  output logic [4:0]  ex_shamt,
  output logic [3:0]  ex_alu_op,
  output logic [31:0] ex_alu_result
);

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign opcode = id_inst[31:26];
  assign rs     = id_inst[25:21];
  assign rt     = id_inst[20:16];
  assign rd     = id_inst[15:11];
  assign shamt  = id_inst[10:6];
  assign funct  = id_inst[5:0];
  assign imm16  = id_inst[15:0];

  ctrl_t      dec;
  logic       sign_ext;
  logic       uses_rs;
  logic       uses_rt;
  logic [4:0] dec_dest;

  // Control unit. Unknown opcodes/functs fall back to all-zero controls and
  // no source use, so they neither write nor interlock.
  always_comb begin
    dec      = CTRL_NOP;
    sign_ext = 1'b0;
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec.regdst   = 1'b1;
        dec.regwrite = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
        case (funct)
          FN_SLL:  begin dec.alu_op = ALU_SLL; uses_rs = 1'b0; end
          FN_SRL:  begin dec.alu_op = ALU_SRL; uses_rs = 1'b0; end
          FN_SRA:  begin dec.alu_op = ALU_SRA; uses_rs = 1'b0; end
          FN_JR:   begin dec.jr = 1'b1; dec.regwrite = 1'b0; uses_rt = 1'b0; end
          FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_XOR:  dec.alu_op = ALU_XOR;
          FN_NOR:  dec.alu_op = ALU_NOR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          FN_SLTU: dec.alu_op = ALU_SLTU;
          default: begin dec = CTRL_NOP; uses_rs = 1'b0; uses_rt = 1'b0; end
        endcase
      end
      OP_J:   dec.jump = 1'b1;
      OP_JAL: begin dec.jump = 1'b1; dec.savepc = 1'b1; dec.regwrite = 1'b1; end
      OP_BEQ, OP_BNE: begin
        dec.branch = 1'b1;
        dec.alu_op = (opcode == OP_BEQ) ? ALU_EQ : ALU_NE;
        sign_ext   = 1'b1;
        uses_rs    = 1'b1;
        uses_rt    = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        sign_ext     = 1'b1;
        uses_rs      = 1'b1;
        dec.alu_op   = (opcode == OP_ADDIU) ? ALU_ADD :
                       (opcode == OP_SLTI)  ? ALU_SLT : ALU_SLTU;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        uses_rs      = 1'b1;
        dec.alu_op   = (opcode == OP_ANDI) ? ALU_AND :
                       (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.alu_op   = ALU_LUI;
      end
      OP_LW: begin
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        sign_ext     = 1'b1;
        uses_rs      = 1'b1;
      end
      OP_SW: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        sign_ext     = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
      end
      default: begin
        dec     = CTRL_NOP;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
      end
    endcase
  end

  assign dec_dest   = dec.regdst ? rd : (dec.savepc ? REG_RA : rt);
  assign id_ext_imm = sign_ext ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};
  assign id_alusrc  = dec.alusrc;

  // ID/EX register state.
  ctrl_t      ex_ctrl;
  logic [4:0] ex_dest_q;
  logic [4:0] ex_shamt_q;

  // A source conflicts if any younger-than-writeback stage will write it.
  // $0 is hardwired, so it never conflicts.
  function automatic logic src_hazard(input logic [4:0] src, input logic [4:0] d_ex,
                                      input logic we_ex, input logic [4:0] d_mem,
                                      input logic we_mem, input logic [4:0] d_wb,
                                      input logic we_wb);
    return (src != 5'd0) &&
           ((we_ex && d_ex == src) || (we_mem && d_mem == src) || (we_wb && d_wb == src));
  endfunction

  assign stall = (uses_rs && src_hazard(rs, ex_dest_q, ex_ctrl.regwrite, ex_mem_wr_reg,
                                        ex_mem_regwrite, mem_wb_wr_reg, mem_wb_regwrite)) ||
                 (uses_rt && src_hazard(rt, ex_dest_q, ex_ctrl.regwrite, ex_mem_wr_reg,
                                        ex_mem_regwrite, mem_wb_wr_reg, mem_wb_regwrite));

  // Reset, flush and bubble all clear the whole entry, so one branch covers them.
  always_ff @(posedge clk) begin
    if (rst || flush || stall) begin
      ex_ctrl    <= CTRL_NOP;
      ex_dest_q  <= 5'd0;
      ex_shamt_q <= 5'd0;
    end else begin
      ex_ctrl    <= dec;
      ex_dest_q  <= dec_dest;
      ex_shamt_q <= shamt;
    end
  end

  assign ex_regdst   = ex_ctrl.regdst;
  assign ex_jump     = ex_ctrl.jump;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_jr       = ex_ctrl.jr;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_savepc   = ex_ctrl.savepc;
  assign ex_dest     = ex_dest_q;
  assign ex_shamt    = ex_shamt_q;
  assign ex_alu_op   = ex_ctrl.alu_op;

  mips_alu u_alu (
    .operand1 (ex_operand1),
    .operand2 (ex_operand2),
    .shamt    (ex_shamt_q),
    .alu_op   (ex_ctrl.alu_op),
    .result   (ex_alu_result)
  );

endmodule

// File: tb/tb_mips_ctrl_alu_hazard.sv
// Self-checking bench for mips_ctrl_alu_hazard: directed scenarios plus a
// randomized instruction stream checked against an instruction-level model.
module tb_mips_ctrl_alu_hazard;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] id_inst;
  logic        flush;
  logic [4:0]  ex_mem_wr_reg;
  logic        ex_mem_regwrite;
  logic [4:0]  mem_wb_wr_reg;
  logic        mem_wb_regwrite;
  logic [31:0] ex_operand1;
  logic [31:0] ex_operand2;
  logic        stall;
  logic [31:0] id_ext_imm;
  logic        id_alusrc;
  logic        ex_regdst, ex_jump, ex_branch, ex_jr, ex_memread, ex_memtoreg;
  logic        ex_memwrite, ex_alusrc, ex_regwrite, ex_savepc;
  logic [4:0]  ex_dest;
  logic [4:0]  ex_shamt;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_alu_result;

  mips_ctrl_alu_hazard dut (
    .clk             (clk),
    .rst             (rst),
    .id_inst         (id_inst),
    .flush           (flush),
    .ex_mem_wr_reg   (ex_mem_wr_reg),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_wr_reg   (mem_wb_wr_reg),
    .mem_wb_regwrite (mem_wb_regwrite),
    .ex_operand1     (ex_operand1),
    .ex_operand2     (ex_operand2),
    .stall           (stall),
    .id_ext_imm      (id_ext_imm),
    .id_alusrc       (id_alusrc),
    .ex_regdst       (ex_regdst),
    .ex_jump         (ex_jump),
    .ex_branch       (ex_branch),
    .ex_jr           (ex_jr),
    .ex_memread      (ex_memread),
    .ex_memtoreg     (ex_memtoreg),
    .ex_memwrite     (ex_memwrite),
    .ex_alusrc       (ex_alusrc),
    .ex_regwrite     (ex_regwrite),
    .ex_savepc       (ex_savepc),
    .ex_dest         (ex_dest),
    .ex_shamt        (ex_shamt),
    .ex_alu_op       (ex_alu_op),
    .ex_alu_result   (ex_alu_result)
  );

  int total = 0;
  int bad   = 0;

  // Registered ID/EX view, 24 bits:
  // [23]regdst [22]jump [21]branch [20]jr [19]memread [18]memtoreg [17]memwrite
  // [16]alusrc [15]regwrite [14]savepc [13:9]dest [8:4]shamt [3:0]alu_op
  logic [23:0] exp_q[$];

  // Instruction kinds
  // 0 sll 1 srl 2 sra 3 jr 4 addu 5 subu 6 and 7 or 8 xor 9 nor 10 slt 11 sltu
  // 12 j 13 jal 14 beq 15 bne 16 addiu 17 slti 18 sltiu 19 andi 20 ori 21 xori
  // 22 lui 23 lw 24 sw

  // ---------------- reference model ----------------
  function automatic logic [31:0] make_inst(int k, int rs, int rt, int rd, int sh, int imm);
    logic [5:0] f;
    logic [5:0] o;
    case (k)
      0: f = 6'h00;  1: f = 6'h02;  2: f = 6'h03;  3: f = 6'h08;
      4: f = 6'h21;  5: f = 6'h23;  6: f = 6'h24;  7: f = 6'h25;
      8: f = 6'h26;  9: f = 6'h27; 10: f = 6'h2A; 11: f = 6'h2B;
      default: f = 6'h00;
    endcase
    case (k)
      12: o = 6'h02; 13: o = 6'h03; 14: o = 6'h04; 15: o = 6'h05;
      16: o = 6'h09; 17: o = 6'h0A; 18: o = 6'h0B; 19: o = 6'h0C;
      20: o = 6'h0D; 21: o = 6'h0E; 22: o = 6'h0F; 23: o = 6'h23;
      24: o = 6'h2B; default: o = 6'h00;
    endcase
    if (k < 12) return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], f};
    return {o, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [23:0] exp_ex(int k, logic [31:0] inst);
    logic regdst, jump, branch, jr, mr, m2r, mw, asrc, rw, spc;
    logic [3:0] op;
    logic [4:0] dest;
    {regdst, jump, branch, jr, mr, m2r, mw, asrc, rw, spc} = '0;
    op = 4'h0;
    if (k < 12) begin regdst = 1; rw = 1; end
    case (k)
      0: op = 4'h8;  1: op = 4'h9;  2: op = 4'hA;
      3: begin jr = 1; rw = 0; end
      4: op = 4'h0;  5: op = 4'h1;  6: op = 4'h2;  7: op = 4'h3;
      8: op = 4'h4;  9: op = 4'h5; 10: op = 4'h6; 11: op = 4'h7;
      12: jump = 1;
      13: begin jump = 1; spc = 1; rw = 1; end
      14: begin branch = 1; op = 4'hC; end
      15: begin branch = 1; op = 4'hD; end
      16: begin asrc = 1; rw = 1; op = 4'h0; end
      17: begin asrc = 1; rw = 1; op = 4'h6; end
      18: begin asrc = 1; rw = 1; op = 4'h7; end
      19: begin asrc = 1; rw = 1; op = 4'h2; end
      20: begin asrc = 1; rw = 1; op = 4'h3; end
      21: begin asrc = 1; rw = 1; op = 4'h4; end
      22: begin asrc = 1; rw = 1; op = 4'hB; end
      23: begin mr = 1; m2r = 1; asrc = 1; rw = 1; end
      24: begin mw = 1; asrc = 1; end
      default: ;
    endcase
    dest = regdst ? inst[15:11] : (spc ? 5'd31 : inst[20:16]);
    return {regdst, jump, branch, jr, mr, m2r, mw, asrc, rw, spc, dest, inst[10:6], op};
  endfunction

  function automatic bit reads_rs(int k);
    return !(k == 0 || k == 1 || k == 2 || k == 22 || k == 12 || k == 13);
  endfunction

  function automatic bit reads_rt(int k);
    return (k < 12 && k != 3) || k == 14 || k == 15 || k == 24;
  endfunction

  function automatic bit is_signext(int k);
    return k == 14 || k == 15 || k == 16 || k == 17 || k == 18 || k == 23 || k == 24;
  endfunction

  // What the instruction computes in EX, stated per mnemonic.
  function automatic logic [31:0] semantic(int k, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    case (k)
      0: return b << sh;
      1: return b >> sh;
      2: return $unsigned($signed(b) >>> sh);
      5: return a - b;
      6, 19: return a & b;
      7, 20: return a | b;
      8, 21: return a ^ b;
      9: return ~(a | b);
      10, 17: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      11, 18: return (a < b) ? 32'd1 : 32'd0;
      14: return (a == b) ? 32'd1 : 32'd0;
      15: return (a != b) ? 32'd1 : 32'd0;
      22: return {b[15:0], 16'h0000};
      default: return a + b;   // addu, addiu, lw, sw, and the jumps (ADD op)
    endcase
  endfunction

  function automatic logic [23:0] get_ex();
    return {ex_regdst, ex_jump, ex_branch, ex_jr, ex_memread, ex_memtoreg, ex_memwrite,
            ex_alusrc, ex_regwrite, ex_savepc, ex_dest, ex_shamt, ex_alu_op};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_stages();
    ex_mem_wr_reg   = 5'd0;
    ex_mem_regwrite = 1'b0;
    mem_wb_wr_reg   = 5'd0;
    mem_wb_regwrite = 1'b0;
    flush           = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    quiet_stages();
    id_inst     = make_inst(4, 1, 2, 3, 0, 0);
    ex_operand1 = 32'd3;
    ex_operand2 = 32'd4;
    tick();
    tick();
    total++;
    if (get_ex() !== 24'h0) begin
      bad++;
      $display("FAIL reset_ex: got %h want 000000", get_ex());
    end
    total++;
    if (ex_alu_result !== 32'd7) begin
      bad++;
      $display("FAIL reset_alu: got %h want 00000007", ex_alu_result);
    end
    rst = 1'b0;
  endtask

  task automatic test_addu();
    id_inst     = make_inst(4, 1, 2, 3, 0, 0);
    ex_operand1 = 32'd7;
    ex_operand2 = 32'd5;
    tick();
    total++;
    if (ex_alu_op !== 4'h0 || ex_dest !== 5'd3 || ex_alu_result !== 32'd12 ||
        ex_regwrite !== 1'b1 || ex_regdst !== 1'b1) begin
      bad++;
      $display("FAIL addu: op=%h dest=%0d res=%0d rw=%b rd=%b want op=0 dest=3 res=12 rw=1 rd=1",
               ex_alu_op, ex_dest, ex_alu_result, ex_regwrite, ex_regdst);
    end
  endtask

  task automatic test_load_use();
    id_inst = make_inst(23, 1, 4, 0, 0, 16);   // lw $4,16($1)
    tick();
    total++;
    if (ex_dest !== 5'd4 || ex_memread !== 1'b1) begin
      bad++;
      $display("FAIL lw_load: dest=%0d memread=%b want 4 1", ex_dest, ex_memread);
    end
    id_inst = make_inst(4, 4, 1, 5, 0, 0);     // addu $5,$4,$1
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL load_use_stall: got %b want 1", stall);
    end
    tick();
    total++;
    if (ex_regwrite !== 1'b0 || get_ex() !== 24'h0) begin
      bad++;
      $display("FAIL bubble: got %h want 000000", get_ex());
    end
    ex_mem_wr_reg   = 5'd4;
    ex_mem_regwrite = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL ex_mem_stall: got %b want 1", stall);
    end
    tick();
    ex_mem_regwrite = 1'b0;
    mem_wb_wr_reg   = 5'd4;
    mem_wb_regwrite = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL mem_wb_stall: got %b want 1", stall);
    end
    mem_wb_regwrite = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL stall_clear: got %b want 0", stall);
    end
    tick();
    total++;
    if (ex_dest !== 5'd5 || ex_regwrite !== 1'b1) begin
      bad++;
      $display("FAIL after_stall: dest=%0d rw=%b want 5 1", ex_dest, ex_regwrite);
    end
  endtask

  task automatic test_zero_src();
    id_inst = 32'h0;                            // sll $0,$0,0
    tick();
    total++;
    if (ex_regwrite !== 1'b1 || ex_dest !== 5'd0) begin
      bad++;
      $display("FAIL nop_decode: rw=%b dest=%0d want 1 0", ex_regwrite, ex_dest);
    end
    ex_mem_wr_reg   = 5'd0;
    ex_mem_regwrite = 1'b1;
    mem_wb_wr_reg   = 5'd0;
    mem_wb_regwrite = 1'b1;
    id_inst = make_inst(4, 0, 0, 5, 0, 0);     // addu $5,$0,$0
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL zero_src_stall: got %b want 0", stall);
    end
    quiet_stages();
  endtask

  task automatic test_branch_slt();
    ex_operand1 = 32'd9;
    ex_operand2 = 32'd9;
    id_inst = make_inst(14, 1, 2, 0, 0, 16'h0010);
    tick();
    total++;
    if (ex_alu_op !== 4'hC || ex_branch !== 1'b1 || ex_regwrite !== 1'b0 ||
        ex_alu_result !== 32'd1) begin
      bad++;
      $display("FAIL beq_eq: op=%h br=%b rw=%b res=%0d want C 1 0 1",
               ex_alu_op, ex_branch, ex_regwrite, ex_alu_result);
    end
    ex_operand2 = 32'd8;
    #1;
    total++;
    if (ex_alu_result !== 32'd0) begin
      bad++;
      $display("FAIL beq_ne: got %0d want 0", ex_alu_result);
    end
    id_inst = make_inst(15, 1, 2, 0, 0, 16'h0010);
    tick();
    total++;
    if (ex_alu_op !== 4'hD || ex_alu_result !== 32'd1) begin
      bad++;
      $display("FAIL bne_ne: op=%h res=%0d want D 1", ex_alu_op, ex_alu_result);
    end
    ex_operand2 = 32'd9;
    #1;
    total++;
    if (ex_alu_result !== 32'd0) begin
      bad++;
      $display("FAIL bne_eq: got %0d want 0", ex_alu_result);
    end
    ex_operand1 = 32'hFFFF_FFFF;
    ex_operand2 = 32'd0;
    id_inst = make_inst(17, 1, 3, 0, 0, 0);
    tick();
    total++;
    if (ex_alu_result !== 32'd1) begin
      bad++;
      $display("FAIL slti: got %0d want 1", ex_alu_result);
    end
    id_inst = make_inst(18, 1, 6, 0, 0, 0);
    tick();
    total++;
    if (ex_alu_result !== 32'd0) begin
      bad++;
      $display("FAIL sltiu: got %0d want 0", ex_alu_result);
    end
  endtask

  task automatic test_shift_lui_imm();
    ex_operand1 = 32'd0;
    ex_operand2 = 32'h8000_0000;
    id_inst = make_inst(2, 0, 2, 7, 4, 0);     // sra $7,$2,4
    tick();
    total++;
    if (ex_alu_result !== 32'hF800_0000 || ex_shamt !== 5'd4) begin
      bad++;
      $display("FAIL sra: res=%h sh=%0d want f8000000 4", ex_alu_result, ex_shamt);
    end
    id_inst = make_inst(1, 0, 2, 7, 4, 0);     // srl $7,$2,4
    tick();
    total++;
    if (ex_alu_result !== 32'h0800_0000) begin
      bad++;
      $display("FAIL srl: got %h want 08000000", ex_alu_result);
    end
    ex_operand2 = 32'h0000_1234;
    id_inst = make_inst(22, 0, 7, 0, 0, 16'h1234);
    tick();
    total++;
    if (ex_alu_result !== 32'h1234_0000) begin
      bad++;
      $display("FAIL lui: got %h want 12340000", ex_alu_result);
    end
    id_inst = make_inst(19, 1, 7, 0, 0, 16'hFFFF);
    #1;
    total++;
    if (id_ext_imm !== 32'h0000_FFFF || id_alusrc !== 1'b1) begin
      bad++;
      $display("FAIL andi_imm: imm=%h alusrc=%b want 0000ffff 1", id_ext_imm, id_alusrc);
    end
    id_inst = make_inst(16, 1, 7, 0, 0, 16'hFFFF);
    #1;
    total++;
    if (id_ext_imm !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL addiu_imm: got %h want ffffffff", id_ext_imm);
    end
    tick();
  endtask

  task automatic test_flush_rst_jal();
    id_inst = make_inst(4, 1, 2, 3, 0, 0);     // addu $3,$1,$2
    tick();
    id_inst = make_inst(4, 3, 1, 5, 0, 0);     // addu $5,$3,$1 -> stalls on $3
    flush   = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL flush_stall_pre: got %b want 1", stall);
    end
    tick();
    total++;
    if (get_ex() !== 24'h0) begin
      bad++;
      $display("FAIL flush_stall: got %h want 000000", get_ex());
    end
    flush   = 1'b0;
    id_inst = make_inst(4, 1, 2, 6, 0, 0);
    tick();
    total++;
    if (ex_dest !== 5'd6) begin
      bad++;
      $display("FAIL after_flush: got %0d want 6", ex_dest);
    end
    rst = 1'b1;
    tick();
    total++;
    if (get_ex() !== 24'h0) begin
      bad++;
      $display("FAIL mid_rst: got %h want 000000", get_ex());
    end
    rst = 1'b0;
    id_inst = make_inst(13, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0,
                        $urandom_range(0, 65535));
    tick();
    total++;
    if (ex_dest !== 5'd31 || ex_savepc !== 1'b1 || ex_jump !== 1'b1 || ex_regwrite !== 1'b1) begin
      bad++;
      $display("FAIL jal: dest=%0d spc=%b jump=%b rw=%b want 31 1 1 1",
               ex_dest, ex_savepc, ex_jump, ex_regwrite);
    end
  endtask

  task automatic test_unknown();
    id_inst = {6'h3F, 26'h2A5_5A5A};
    tick();
    total++;
    if (get_ex() & 24'hFFC00F) begin
      bad++;
      $display("FAIL unknown_op: got %h want controls and op zero", get_ex());
    end
    id_inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h01};
    tick();
    total++;
    if (get_ex() & 24'hFFC00F) begin
      bad++;
      $display("FAIL unknown_funct: got %h want controls and op zero", get_ex());
    end
  endtask

  // Back-to-back random stream: hazards, flushes and operands all randomized.
  task automatic test_random();
    logic [4:0]  m_dest;
    logic        m_rw;
    logic [23:0] e;
    logic [31:0] inst, exp_res, exp_imm;
    bit          hz, fl;
    int          k, rs, rt, rd;

    rst = 1'b1;
    quiet_stages();
    tick();
    rst    = 1'b0;
    m_dest = 5'd0;
    m_rw   = 1'b0;
    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 24);
      rs = $urandom_range(0, 7);
      rt = $urandom_range(0, 7);
      rd = $urandom_range(0, 7);
      inst = make_inst(k, rs, rt, rd, $urandom_range(0, 31), $urandom_range(0, 65535));
      ex_mem_wr_reg   = 5'($urandom_range(0, 7));
      ex_mem_regwrite = 1'($urandom_range(0, 1));
      mem_wb_wr_reg   = 5'($urandom_range(0, 7));
      mem_wb_regwrite = 1'($urandom_range(0, 1));
      fl          = ($urandom_range(0, 9) == 0);
      flush       = fl;
      ex_operand1 = $urandom;
      ex_operand2 = (k == 2 || k == 10 || k == 17) ? ($urandom | 32'h8000_0000) : $urandom;
      id_inst     = inst;

      hz = 0;
      if (reads_rs(k) && rs != 0 &&
          ((m_rw && m_dest == rs[4:0]) ||
           (ex_mem_regwrite && ex_mem_wr_reg == rs[4:0]) ||
           (mem_wb_regwrite && mem_wb_wr_reg == rs[4:0])))
        hz = 1;
      if (reads_rt(k) && rt != 0 &&
          ((m_rw && m_dest == rt[4:0]) ||
           (ex_mem_regwrite && ex_mem_wr_reg == rt[4:0]) ||
           (mem_wb_regwrite && mem_wb_wr_reg == rt[4:0])))
        hz = 1;
      exp_imm = is_signext(k) ? {{16{inst[15]}}, inst[15:0]} : {16'h0000, inst[15:0]};

      #1;
      total++;
      if (stall !== hz) begin
        bad++;
        $display("FAIL rnd_stall n=%0d inst=%h: got %b want %b", n, inst, stall, hz);
      end
      total++;
      if (id_ext_imm !== exp_imm || id_alusrc !== (k >= 16)) begin
        bad++;
        $display("FAIL rnd_imm n=%0d inst=%h: imm=%h src=%b want %h %b",
                 n, inst, id_ext_imm, id_alusrc, exp_imm, (k >= 16));
      end

      e = (fl || hz) ? 24'h0 : exp_ex(k, inst);
      exp_q.push_back(e);
      exp_res = (fl || hz) ? ex_operand1 + ex_operand2
                           : semantic(k, ex_operand1, ex_operand2, inst[10:6]);
      tick();
      e = exp_q.pop_front();
      total++;
      if (get_ex() !== e) begin
        bad++;
        $display("FAIL rnd_ex n=%0d inst=%h: got %h want %h", n, inst, get_ex(), e);
      end
      total++;
      if (ex_alu_result !== exp_res) begin
        bad++;
        $display("FAIL rnd_alu n=%0d inst=%h: got %h want %h", n, inst, ex_alu_result, exp_res);
      end
      m_dest = e[13:9];
      m_rw   = e[15];
    end
    flush = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    quiet_stages();
    id_inst     = 32'h0;
    ex_operand1 = 32'h0;
    ex_operand2 = 32'h0;
    test_reset();
    test_addu();
    test_load_use();
    test_zero_src();
    test_branch_slt();
    test_shift_lui_imm();
    test_flush_rst_jal();
    test_unknown();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
